// File: rtl/legv8_pkg.sv
// Shared LEGv8 definitions used by the fetch stage.
//   INSTR_W     : instruction word width
//   OP_B, OP_BL : primary opcodes (bits [31:26]) of the unconditional branches
//   fetch_state_e : fetch FSM states
//   is_uncond_branch() : true for B / BL instruction words
package legv8_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [5:0] OP_B  = 6'b000101;
  localparam logic [5:0] OP_BL = 6'b100101;

  typedef enum logic [1:0] {
    ST_REQ,
    ST_WAIT,
    ST_DROP
  } fetch_state_e;

  function automatic logic is_uncond_branch(input logic [INSTR_W-1:0] instr);
    return (instr[31:26] == OP_B) || (instr[31:26] == OP_BL);
  endfunction

endpackage

// File: rtl/legv8_fetch_unit_fifo.sv
// fetch_fifo: 2-entry FIFO of {pc, instr} pairs feeding the decoder.
//   clk, rst_n           : clock, asynchronous active-low reset
//   push, push_pc/instr  : write an entry (ignored when full)
//   pop                  : drop the head entry (ignored when empty)
//   flush                : empty the FIFO; wins over push and pop
//   count                : occupancy 0..2
//   head_pc, head_instr  : contents of the head entry
module fetch_fifo
  import legv8_pkg::*;
#(
  parameter int unsigned PC_W = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [PC_W-1:0]    push_pc,
  input  logic [INSTR_W-1:0] push_instr,
  input  logic               pop,
  input  logic               flush,
  output logic [1:0]         count,
  output logic [PC_W-1:0]    head_pc,
  output logic [INSTR_W-1:0] head_instr
);

  logic [PC_W-1:0]    pc_q    [2];
  logic [INSTR_W-1:0] instr_q [2];
  logic               wr_ptr;
  logic               rd_ptr;
  logic [1:0]         cnt;
  logic               do_push;
  logic               do_pop;

  assign do_push    = push && (cnt != 2'd2);
  assign do_pop     = pop && (cnt != 2'd0);
  assign count      = cnt;
  assign head_pc    = pc_q[rd_ptr];
  assign head_instr = instr_q[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        pc_q[wr_ptr]    <= push_pc;
        instr_q[wr_ptr] <= push_instr;
        wr_ptr          <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/legv8_fetch_unit.sv
// legv8_fetch_unit: LEGv8 instruction fetch stage.
// Owns the PC, keeps at most one instruction-memory read outstanding,
// buffers responses in a 2-entry FIFO and hands them to the decoder.
//   clk, rst_n                   : clock, asynchronous active-low reset
//   imem_req/addr/ready          : read request channel (word aligned)
//   imem_rvalid/rdata            : in-order read response channel
//   redirect_valid, redirect_pc  : flush and refetch from a new target
//   if_valid, if_instr, if_pc    : decoder-facing head of the FIFO
//   id_ready                     : decoder consumes the head
// Optional macro FETCH_STATIC_BRANCH_EN: follow B/BL targets at fetch time.
module legv8_fetch_unit
  import legv8_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  input  logic               id_ready
);

  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
  localparam logic [PC_W-1:0] ALIGN_MASK = ~PC_W'(3);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0] req_pc_q, req_pc_d;
  logic            started_q;
  logic [1:0]      count;
  logic            handshake;
  logic            push;
  logic            pop;
  logic            flush;
  logic [PC_W-1:0] next_pc;

  // started_q holds requests off until the first edge after reset release,
  // so imem_req reads 0 throughout reset without using rst_n as data.
  assign imem_req  = started_q && (state_q == ST_REQ) && (count < 2'd2);
  assign imem_addr = fetch_pc_q & ALIGN_MASK;
  assign handshake = imem_req && imem_ready;
  assign if_valid  = (count != 2'd0);
  assign pop       = if_valid && id_ready;

`ifdef FETCH_STATIC_BRANCH_EN
  logic [PC_W-1:0] branch_off;
  assign branch_off = {{(PC_W-28){imem_rdata[25]}}, imem_rdata[25:0], 2'b00};
  assign next_pc = is_uncond_branch(imem_rdata) ? (req_pc_q + branch_off)
                                                : (req_pc_q + PC_STEP);
`else
  assign next_pc = req_pc_q + PC_STEP;
`endif

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    push       = 1'b0;
    flush      = 1'b0;

    unique case (state_q)
      ST_REQ: begin
        if (handshake) begin
          req_pc_d = fetch_pc_q;
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          push       = 1'b1;
          fetch_pc_d = next_pc;
          state_d    = ST_REQ;
        end
      end
      ST_DROP: begin
        if (imem_rvalid) begin
          state_d = ST_REQ;
        end
      end
      default: state_d = ST_REQ;
    endcase

    // Redirect overrides the normal path. A response landing in the same
    // cycle (WAIT or DROP) retires the outstanding read, so the base
    // transition to REQ is kept; only a still-pending read forces DROP.
    if (redirect_valid) begin
      flush      = 1'b1;
      push       = 1'b0;
      fetch_pc_d = redirect_pc & ALIGN_MASK;
      if ((state_q == ST_REQ) && handshake) begin
        state_d = ST_DROP;
      end else if ((state_q == ST_WAIT) && !imem_rvalid) begin
        state_d = ST_DROP;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_REQ;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      started_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      started_q  <= 1'b1;
    end
  end

  fetch_fifo #(
    .PC_W(PC_W)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_pc    (req_pc_q),
    .push_instr (imem_rdata),
    .pop        (pop),
    .flush      (flush),
    .count      (count),
    .head_pc    (if_pc),
    .head_instr (if_instr)
  );

endmodule

// File: tb/tb_legv8_fetch_unit.sv
// Scoreboard bench for legv8_fetch_unit: a memory model answers granted
// requests after a programmable latency; expected request addresses and
// decoder-side outputs are queued by the directed tests and checked by
// independent monitors.
module tb_legv8_fetch_unit;

  localparam logic [31:0] ADD_W = 32'h8B18012B;
  localparam logic [31:0] B_W   = 32'h14000041;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic        id_ready;

  typedef struct {
    logic [63:0] addr;
    int unsigned due;
  } mem_txn_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } out_t;

  mem_txn_t    pend[$];
  logic [63:0] exp_req[$];
  out_t        exp_out[$];

  int unsigned grants;
  int unsigned lat;
  int unsigned cyc;
  bit          branch_at_8;
  int          n_cmp;
  int          n_err;

  legv8_fetch_unit #(
    .PC_W     (64),
    .RESET_PC (64'h0)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .id_ready       (id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [63:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got unexpected value %h expected none", name, act);
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (branch_at_8 && (a == 64'h8)) return B_W;
    return ADD_W;
  endfunction

  // Memory model and request checker: runs 1 time unit after each negedge.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    if ((pend.size() > 0) && (pend[0].due <= cyc)) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
    imem_ready = (grants > 0);
    if (imem_req && imem_ready) begin
      grants--;
      if (exp_req.size() == 0) unexpected("req_addr", imem_addr);
      else check("req_addr", imem_addr, exp_req.pop_front());
      pend.push_back('{addr: imem_addr, due: cyc + lat});
    end
  end

  // Decoder-side monitor: checks every consumed instruction.
  always begin
    @(negedge clk);
    #4;
    if (rst_n && if_valid && id_ready) begin
      if (exp_out.size() == 0) begin
        unexpected("out_pc", if_pc);
      end else begin
        out_t e;
        e = exp_out.pop_front();
        check("out_pc", if_pc, e.pc);
        check("out_instr", {32'h0, if_instr}, {32'h0, e.instr});
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic push_out(input logic [63:0] pc, input logic [31:0] instr);
    exp_out.push_back('{pc: pc, instr: instr});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {63'h0, imem_req}, 64'h0);
    check({tag, "_addr"},  imem_addr, 64'h0);
    check({tag, "_valid"}, {63'h0, if_valid}, 64'h0);
    check({tag, "_instr"}, {32'h0, if_instr}, 64'h0);
    check({tag, "_pc"},    if_pc, 64'h0);
  endtask

  // Leaves the bench at the first cycle in which the DUT requests.
  task automatic do_reset();
    @(negedge clk);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    #2;
    check_reset_outputs("rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("req_at_release", {63'h0, imem_req}, 64'h0);
    tick();
    check("first_req", {63'h0, imem_req}, 64'h1);
    check("first_addr", imem_addr, 64'h0);
  endtask

  task automatic wait_drain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      if ((exp_req.size() == 0) && (exp_out.size() == 0) && (pend.size() == 0)) break;
      tick();
    end
    check(name, 64'(exp_req.size() + exp_out.size() + pend.size()), 64'h0);
    repeat (4) tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    cyc            = 0;
    grants         = 0;
    lat            = 1;
    branch_at_8    = 1'b0;
    rst_n          = 1'b0;
    imem_ready     = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b0;

    // Sequential fetch, 1-cycle memory.
    lat = 1; grants = 3; id_ready = 1'b1;
    exp_req.push_back(64'h0); exp_req.push_back(64'h4); exp_req.push_back(64'h8);
    push_out(64'h0, ADD_W); push_out(64'h4, ADD_W); push_out(64'h8, ADD_W);
    do_reset();
    wait_drain("seq_drain", 40);

    // Backpressure: two responses fill the FIFO, then requests stop.
    lat = 1; grants = 2; id_ready = 1'b0;
    exp_req.push_back(64'h0); exp_req.push_back(64'h4);
    do_reset();
    repeat (8) tick();
    check("bp_req_off", {63'h0, imem_req}, 64'h0);
    check("bp_valid", {63'h0, if_valid}, 64'h1);
    check("bp_head_pc", if_pc, 64'h0);
    push_out(64'h0, ADD_W); push_out(64'h4, ADD_W);
    id_ready = 1'b1;
    wait_drain("bp_drain", 40);

    // Redirect while a 3-cycle read is outstanding; low target bits ignored.
    lat = 3; grants = 1; id_ready = 1'b1;
    exp_req.push_back(64'h0);
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h102;
    grants         = 1;
    exp_req.push_back(64'h100);
    push_out(64'h100, ADD_W);
    tick();
    redirect_valid = 1'b0;
    check("drop_no_req", {63'h0, imem_req}, 64'h0);
    wait_drain("drop_drain", 40);

    // Redirect coincident with a response while the FIFO holds an entry.
    lat = 1; grants = 2; id_ready = 1'b0;
    exp_req.push_back(64'h0); exp_req.push_back(64'h4);
    do_reset();
    repeat (3) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 64'h200;
    grants         = 1;
    exp_req.push_back(64'h200);
    push_out(64'h200, ADD_W);
    tick();
    redirect_valid = 1'b0;
    check("coin_valid", {63'h0, if_valid}, 64'h0);
    check("coin_req", {63'h0, imem_req}, 64'h1);
    check("coin_addr", imem_addr, 64'h200);
    id_ready = 1'b1;
    wait_drain("coin_drain", 40);

    // Unconditional branch B at PC 0x8.
    lat = 1; grants = 4; id_ready = 1'b1; branch_at_8 = 1'b1;
    exp_req.push_back(64'h0); exp_req.push_back(64'h4); exp_req.push_back(64'h8);
`ifdef FETCH_STATIC_BRANCH_EN
    exp_req.push_back(64'h10C);
    push_out(64'h0, ADD_W); push_out(64'h4, ADD_W); push_out(64'h8, B_W); push_out(64'h10C, ADD_W);
`else
    exp_req.push_back(64'hC);
    push_out(64'h0, ADD_W); push_out(64'h4, ADD_W); push_out(64'h8, B_W); push_out(64'hC, ADD_W);
`endif
    do_reset();
    wait_drain("br_drain", 40);
    branch_at_8 = 1'b0;

    // PC wraps past the top of the address space.
    lat = 1; grants = 0; id_ready = 1'b1;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    grants         = 2;
    exp_req.push_back(64'hFFFF_FFFF_FFFF_FFFC); exp_req.push_back(64'h0);
    push_out(64'hFFFF_FFFF_FFFF_FFFC, ADD_W); push_out(64'h0, ADD_W);
    tick();
    redirect_valid = 1'b0;
    wait_drain("wrap_drain", 40);

    // Reset while a read is outstanding; the late response must vanish.
    lat = 3; grants = 2; id_ready = 1'b0;
    exp_req.push_back(64'h0); exp_req.push_back(64'h4);
    do_reset();
    repeat (5) tick();
    check("mid_valid_before", {63'h0, if_valid}, 64'h1);
    check("mid_addr_before", imem_addr, 64'h4);
    rst_n    = 1'b0;
    id_ready = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) tick();
    check("late_rsp_valid", {63'h0, if_valid}, 64'h0);
    wait_drain("mid_drain", 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/legv8_fetch_unit.md
# legv8_fetch_unit

Instruction fetch stage for the LEGv8 single-issue core. It sits directly upstream of the decoder/controller. It owns the program counter and issues word reads to instruction memory with at most one read outstanding. It buffers returned instructions in a 2-entry FIFO and presents them to the decoder over a valid/ready handshake. It also accepts PC redirects from the branch-resolution logic downstream.

## Interface
- `PC_W`, 64: program counter width in bits.
- `RESET_PC`, 0: PC value loaded at reset. Must be 4-byte aligned.
- `clk`  in  1: the single clock. All state updates on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `imem_req`  out  1: read request to instruction memory.
- `imem_addr`  out  PC_W: byte address of the request. Bits [1:0] are always 0.
- `imem_ready`  in  1: memory accepts the request in this cycle.
- `imem_rvalid`  in  1: read data is valid. Responses return in order, latency ≥1 cycle.
- `imem_rdata`  in  32: instruction word.
- `redirect_valid`  in  1: downstream branch taken; flush and refetch.
- `redirect_pc`  in  PC_W: redirect target. Bits [1:0] are ignored and treated as 0.
- `if_valid`  out  1: the FIFO head holds an instruction.
- `if_instr`  out  32: instruction word at the FIFO head, fed to the decoder's Instruction input.
- `if_pc`  out  PC_W: address of `if_instr`.
- `id_ready`  in  1: the decoder consumes the head in this cycle.

## Operation
- Registers: `fetch_pc`, FSM state, FIFO of 2 entries of {pc, instr}, `count` (0..2), and `req_pc` (address of the outstanding request).
- FSM states:
  - REQ: `imem_req` is 1 when `count` < 2. A handshake (`imem_req & imem_ready`) latches `req_pc` = `fetch_pc` and moves to WAIT.
  - WAIT: on `imem_rvalid`, push {`req_pc`, `imem_rdata`} into the FIFO, set `fetch_pc` = `req_pc` + 4, and return to REQ.
  - DROP: wait for the stale response. On `imem_rvalid`, discard it and go to REQ.
- Request gating: a request is issued only when `count` < 2. Because at most one read is outstanding, a response can never hit a full FIFO. While in WAIT, the FIFO may only drain.
- Pop: when `if_valid & id_ready`. A push and a pop in the same cycle leaves `count` unchanged.
- Redirect has the highest priority and is applied in any state:
  - Flush the FIFO (`count` = 0) and set `fetch_pc` = `redirect_pc`.
  - If a request is outstanding, or is handshaken in this same cycle, go to DROP. The exception is WAIT with `imem_rvalid` in the same cycle: that response is discarded and the FSM goes to REQ.
  - Otherwise stay in or return to REQ.
  - A redirect while in DROP keeps DROP and updates `fetch_pc`.
- PC arithmetic is modulo 2^PC_W. Incrementing past the top address wraps silently.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `if_valid`=0, `if_instr`=0, `if_pc`=0, state=REQ, `count`=0.
- First request: `imem_req`=1 in the first cycle after `rst_n` deasserts.
- `imem_addr` and `imem_req` are driven combinationally from registered state and `count`. They do not depend on `imem_rvalid` or `id_ready`.
- Response at edge N produces `if_valid`=1 after edge N (registered FIFO). Latency is 1 cycle from `imem_rvalid` to decoder visibility.
- Throughput with 1-cycle memory: one instruction per 2 cycles (REQ then WAIT).
- Redirect at edge N: `if_valid`=0 after N. The next request is issued to `redirect_pc` in cycle N+1 if nothing is outstanding; otherwise it is issued after the stale response drains.
- `rst_n` asserted mid-operation immediately clears all state. A response arriving during or after reset that has no matching request is ignored because the FSM is in REQ.

## Configuration
- `FETCH_STATIC_BRANCH_EN` defined:
  - Predecode responses accepted in WAIT. If `imem_rdata[31:26]` is 000101 (B) or 100101 (BL), set `fetch_pc` = `req_pc` + (sign_extend(`imem_rdata[25:0]`) << 2) instead of +4.
  - The instruction is still pushed, so BL's link write happens downstream.
  - An external redirect in the same cycle still wins.
- `FETCH_STATIC_BRANCH_EN` undefined: `fetch_pc` always advances by 4. B and BL are resolved only via `redirect_valid`.

## Structure
- Shared package `legv8_pkg`: opcode constants `OP_B`=6'b000101 and `OP_BL`=6'b100101, the FSM state enum, and instruction width 32.
- One sub-module is natural: `fetch_fifo`, a 2-entry {pc, instr} FIFO with push, pop, flush, count, and head outputs. Flush has priority over push.

## Test plan
- Reset and sequential fetch: `RESET_PC`=0, 1-cycle memory returning 0x8B18012B (ADD X11,X9,X24) at every address, `id_ready`=1. The bench must see requests to addresses 0x0, 0x4, 0x8 and `if_pc` values 0x0, 0x4, 0x8, each with `if_instr`=0x8B18012B.
- Backpressure: hold `id_ready`=0. Exactly 2 responses are pushed, then `imem_req` stays 0. Releasing `id_ready` delivers PCs 0x0 and 0x4 in order with no loss.
- Redirect with an outstanding read: memory latency 3, assert redirect to 0x100 while in WAIT. The stale response is dropped, the next request address is 0x100, and the first `if_pc` after the redirect is 0x100.
- Redirect coincident with response: `redirect_valid` and `imem_rvalid` in the same cycle. The FIFO ends empty, the next request is 0x200 one cycle later, and no DROP occurs.
- Static branch (macro on): B 0x14000041 returned at PC 0x8. The next request address is 0x10C, and B is still presented at `if_pc`=0x8. With the macro off, the next request address is 0xC.
- Reset mid-WAIT: assert `rst_n`=0 while a read is outstanding. Outputs return to their reset values immediately, and a late `imem_rvalid` produces no `if_valid`.
